// File: rtl/led_matrix_scan.sv
`default_nettype none
// ============================================================================
// led_matrix_scan : 8x8 LED matrix row scanner with inter-row blanking.
//   Double buffering is enabled by defining LED_MATRIX_DOUBLE_BUFFER_EN.
// Revision: 1.0
// ============================================================================
module led_matrix_scan #(
  parameter int unsigned DWELL_CYCLES = 1024,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       commit,
  output logic [7:0] row,
  output logic [7:0] d,
  output logic       frame_start,
  output logic       swap_pending
);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  localparam logic [15:0] c_DWELL_LAST = 16'(DWELL_CYCLES - 1);
  localparam logic [15:0] c_BLANK_LAST = 16'(BLANK_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [2:0]  r_idx, w_idx_nxt;
  logic [7:0]  r_row, w_row_nxt;
  logic [7:0]  r_d, w_d_nxt;
  logic        r_frame_start, w_frame_start_nxt;
  logic        w_frame_end;
  logic [7:0]  w_front_row;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state       <= ST_BLANK;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_row         <= 8'h00;
      r_d           <= 8'hFF;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_idx         <= w_idx_nxt;
      r_row         <= w_row_nxt;
      r_d           <= w_d_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  // Row and column drive are loaded only on state changes, so a row's data
  // is fixed for its whole dwell even if the buffer is rewritten meanwhile.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt + 16'd1;
    w_idx_nxt         = r_idx;
    w_row_nxt         = r_row;
    w_d_nxt           = r_d;
    w_frame_start_nxt = 1'b0;
    w_frame_end       = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == c_BLANK_LAST) begin
          w_state_nxt       = ST_DRIVE;
          w_cnt_nxt         = '0;
          w_row_nxt         = 8'd1 << r_idx;
          w_d_nxt           = ~w_front_row;
          w_frame_start_nxt = (r_idx == 3'd0);
        end
      end
      ST_DRIVE: begin
        if (r_cnt == c_DWELL_LAST) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = r_idx + 3'd1;
          w_row_nxt   = 8'h00;
          w_d_nxt     = 8'hFF;
          w_frame_end = (r_idx == 3'd7);
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef LED_MATRIX_DOUBLE_BUFFER_EN
  logic [7:0] r_bank [2][8];
  logic       r_front_sel;
  logic       r_swap_pending;

  assign w_front_row = r_bank[r_front_sel][r_idx];

  // CPU writes always target the back bank; at a swap that bank becomes
  // front, so a write on the swap edge is shown in the following frame.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 8; i++) begin
          r_bank[b][i] <= 8'h00;
        end
      end
      r_front_sel    <= 1'b0;
      r_swap_pending <= 1'b0;
    end else begin
      if (wr_en) begin
        r_bank[~r_front_sel][wr_addr] <= wr_data;
      end
      if (w_frame_end && (commit || r_swap_pending)) begin
        r_front_sel    <= ~r_front_sel;
        r_swap_pending <= 1'b0;
      end else if (commit) begin
        r_swap_pending <= 1'b1;
      end
    end
  end

  assign swap_pending = r_swap_pending;
`else
  logic [7:0] r_bank [8];
  logic       w_unused_inputs;

  assign w_front_row     = r_bank[r_idx];
  assign w_unused_inputs = commit ^ w_frame_end;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        r_bank[i] <= 8'h00;
      end
    end else if (wr_en) begin
      r_bank[wr_addr] <= wr_data;
    end
  end

  assign swap_pending = 1'b0;
`endif

  assign row         = r_row;
  assign d           = r_d;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scan.sv
`default_nettype none
// ============================================================================
// tb_led_matrix_scan : randomized self-checking bench for led_matrix_scan.
// Revision: 1.0
// ============================================================================
module tb_led_matrix_scan;

  localparam int DW    = 4;
  localparam int BL    = 1;
  localparam int SLOT  = DW + BL;
  localparam int FRAME = 8 * SLOT;

  logic       clock;
  logic       reset_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       commit;
  logic [7:0] row;
  logic [7:0] d;
  logic       frame_start;
  logic       swap_pending;

  int n_checks;
  int n_fail;

  led_matrix_scan #(
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit      (commit),
    .row         (row),
    .d           (d),
    .frame_start (frame_start),
    .swap_pending(swap_pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%02h required=%02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: time position within the frame -----
  int unsigned m_t;
  logic [7:0]  m_bank [2][8];
  bit          m_front;
  bit          m_pend;
  bit          m_valid;
  logic [7:0]  m_latch;
  int          p_old;
  int          p_new;

  initial m_valid = 1'b0;

  always @(posedge clock) begin
    if (!reset_n) begin
      m_t = 0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 8; i++) m_bank[b][i] = 8'h00;
      m_front = 1'b0;
      m_pend  = 1'b0;
      m_latch = 8'h00;
      m_valid = 1'b1;
    end else if (m_valid) begin
      p_old = int'(m_t % FRAME);
      m_t   = m_t + 1;
      p_new = int'(m_t % FRAME);
      if (p_new % SLOT == BL) m_latch = m_bank[m_front][p_new / SLOT];
`ifdef LED_MATRIX_DOUBLE_BUFFER_EN
      if (wr_en) m_bank[!m_front][wr_addr] = wr_data;
      if (p_old == FRAME - 1 && (commit || m_pend)) begin
        m_front = !m_front;
        m_pend  = 1'b0;
      end else if (commit) begin
        m_pend = 1'b1;
      end
`else
      if (wr_en) m_bank[0][wr_addr] = wr_data;
`endif
    end
  end

  // ---------------- per-cycle comparison ----------------------------------
  int         c_p;
  int         c_idx;
  int         c_o;
  logic [7:0] e_row;
  logic [7:0] e_d;
  logic       e_fs;

  always @(negedge clock) begin
    if (m_valid) begin
      c_p   = int'(m_t % FRAME);
      c_idx = c_p / SLOT;
      c_o   = c_p % SLOT;
      if (c_o >= BL) begin
        e_row = 8'd1 << c_idx;
        e_d   = ~m_latch;
      end else begin
        e_row = 8'h00;
        e_d   = 8'hFF;
      end
      e_fs = (c_idx == 0) && (c_o == BL);
      chk("row", row, e_row);
      chk("d", d, e_d);
      chk("frame_start", 8'(frame_start), 8'(e_fs));
      chk("swap_pending", 8'(swap_pending), 8'(m_pend));
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s timeout actual=none required=event", name);
  endtask

  task automatic wait_row(input logic [7:0] r);
    int k;
    k = 0;
    while (row !== r && k < 200) begin
      tick;
      k++;
    end
    if (row !== r) timeout_fail("wait_row");
  endtask

  task automatic wait_fs;
    int k;
    k = 0;
    do begin
      tick;
      k++;
    end while (frame_start !== 1'b1 && k < 200);
    if (frame_start !== 1'b1) timeout_fail("wait_frame_start");
  endtask

  int k;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = 3'd0;
    wr_data  = 8'h00;
    commit   = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
    chk("rst_row", row, 8'h00);
    chk("rst_d", d, 8'hFF);
    chk("rst_fs", 8'(frame_start), 8'h00);
    chk("rst_sp", 8'(swap_pending), 8'h00);
    tick;
    chk("first_row", row, 8'h01);
    chk("first_d", d, 8'hFF);
    chk("first_fs", 8'(frame_start), 8'h01);
    k = 0;
    do begin
      tick;
      k++;
      if (k == 5) chk("row_walk", row, 8'h02);
    end while (frame_start !== 1'b1 && k < 100);
    chk("frame_period", 8'(k), 8'd40);

    // Row-3 write plus commit during row 0 of a frame
`ifdef LED_MATRIX_DOUBLE_BUFFER_EN
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5; commit = 1'b1;
    tick;
    wr_en = 1'b0; commit = 1'b0;
    chk("sp_after_commit", 8'(swap_pending), 8'h01);
    wait_row(8'h08);
    chk("pre_swap_d", d, 8'hFF);
    chk("pre_swap_sp", 8'(swap_pending), 8'h01);
    wait_fs;
    chk("post_swap_sp", 8'(swap_pending), 8'h00);
    wait_row(8'h08);
    chk("post_swap_d", d, 8'h5A);

    // Commit plus row-7 write on the exact frame-end cycle
    wait_row(8'h80);
    tick; tick; tick;
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'hFF; commit = 1'b1;
    tick;
    wr_en = 1'b0; commit = 1'b0;
    chk("frame_end_commit_sp", 8'(swap_pending), 8'h00);
    wait_row(8'h80);
    chk("swap_cycle_write_d", d, 8'h00);
`else
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h0F; commit = 1'b1;
    tick;
    wr_en = 1'b0; commit = 1'b0;
    chk("single_same_row_d", d, 8'hFF);
    chk("single_sp", 8'(swap_pending), 8'h00);
    wait_fs;
    chk("single_next_row0_d", d, 8'hF0);
    chk("single_sp_later", 8'(swap_pending), 8'h00);
`endif

    // Reset during row 5 drive with a commit outstanding
    commit = 1'b1;
    tick;
    commit = 1'b0;
    wait_row(8'h20);
    reset_n = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C; commit = 1'b1;
    tick;
    reset_n = 1'b1;
    wr_en = 1'b0; commit = 1'b0;
    chk("midreset_row", row, 8'h00);
    chk("midreset_d", d, 8'hFF);
    chk("midreset_sp", 8'(swap_pending), 8'h00);
    tick;
    chk("restart_row", row, 8'h01);
    chk("restart_fs", 8'(frame_start), 8'h01);

    // Randomized traffic with occasional resets
    repeat (3000) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 8'($urandom_range(0, 255));
      commit  = ($urandom_range(0, 29) == 0);
      reset_n = ($urandom_range(0, 499) != 0);
      tick;
    end
    wr_en   = 1'b0;
    commit  = 1'b0;
    reset_n = 1'b1;
    repeat (50) tick;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
